// File: rtl/instr_mem_fetch_q.sv
// -----------------------------------------------------------------------------
// instr_mem_fetch_q
//
// Read-only instruction memory behind a request/response handshake. Each
// accepted fetch produces one response, held in a 2-entry in-order queue.
// A response is visible on the outputs right after the edge that accepted
// its request. Misaligned or out-of-range addresses return an error flag
// with zero data. A free-running counter tracks accepted fetches.
//
// Ports:
//   i_clk          system clock, all state updates on the rising edge
//   i_reset        synchronous active-high reset (priority over everything)
//   i_flush        synchronous discard of all queued responses
//   i_req_valid    fetch request present
//   o_req_ready    block can accept a request this cycle
//   i_address      byte address of the requested instruction
//   o_resp_valid   head-of-queue response valid
//   i_resp_ready   consumer accepts the head response this cycle
//   o_resp_data    instruction word (zero on error)
//   o_resp_err     request was misaligned or out of range
//   o_fetch_count  number of accepted requests since reset (wraps)
// -----------------------------------------------------------------------------
module instr_mem_fetch_q #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 7,
    parameter int INIT_MULT  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [31:0]           i_address,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_resp_data,
    output logic                  o_resp_err,
    output logic [CNT_WIDTH-1:0]  o_fetch_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    generate
        if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 30 || DATA_WIDTH < 1) begin : g_bad_params
            $error("instr_mem_fetch_q: DEPTH_LOG2 must be 1..30 and DATA_WIDTH >= 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Constant instruction image: word[i] = i * INIT_MULT, truncated.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_rom [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign w_rom[gi] = DATA_WIDTH'(64'(gi) * 64'(INIT_MULT));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_new_err;
    logic [DATA_WIDTH-1:0] w_new_data;

    assign w_index        = i_address[DEPTH_LOG2+1:2];
    assign w_misaligned   = |i_address[1:0];
    // Shift rather than slice so DEPTH_LOG2 = 30 (empty upper field) is legal.
    assign w_out_of_range = (i_address >> (DEPTH_LOG2 + 2)) != 32'd0;
    assign w_new_err      = w_misaligned | w_out_of_range;
    assign w_new_data     = w_new_err ? '0 : w_rom[w_index];

    // -------------------------------------------------------------------------
    // Queue state. The head slot drives the response outputs directly, so it
    // keeps its last value once the queue drains.
    // -------------------------------------------------------------------------
    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_head_data;
    logic                  r_head_err;
    logic [DATA_WIDTH-1:0] r_tail_data;
    logic                  r_tail_err;
    logic [CNT_WIDTH-1:0]  r_fetch_count;

    logic w_accept;
    logic w_pop;

    // Ready depends only on registered occupancy and flush.
    assign o_req_ready   = !i_flush && (r_count < 2'd2);
    assign o_resp_valid  = (r_count != 2'd0);
    assign o_resp_data   = r_head_data;
    assign o_resp_err    = r_head_err;
    assign o_fetch_count = r_fetch_count;

    assign w_accept = i_req_valid && o_req_ready;
    assign w_pop    = o_resp_valid && i_resp_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count       <= 2'd0;
            r_head_data   <= '0;
            r_head_err    <= 1'b0;
            r_fetch_count <= '0;
        end else if (i_flush) begin
            // Accept is already blocked by ready; any pop is moot.
            r_count <= 2'd0;
        end else begin
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + 1'b1;
            end

            if (w_accept && w_pop) begin
                // Only possible at count 1: new entry replaces the head.
                r_head_data <= w_new_data;
                r_head_err  <= w_new_err;
            end else if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_head_data <= r_tail_data;
                    r_head_err  <= r_tail_err;
                end
                r_count <= r_count - 2'd1;
            end else if (w_accept) begin
                if (r_count == 2'd0) begin
                    r_head_data <= w_new_data;
                    r_head_err  <= w_new_err;
                end else begin
                    r_tail_data <= w_new_data;
                    r_tail_err  <= w_new_err;
                end
                r_count <= r_count + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch_q.sv
module tb_instr_mem_fetch_q;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_req_valid = 1'b0;
    logic [31:0] i_address = '0;
    logic        i_resp_ready = 1'b0;
    logic        o_req_ready;
    logic        o_resp_valid;
    logic [31:0] o_resp_data;
    logic        o_resp_err;
    logic [15:0] o_fetch_count;

    instr_mem_fetch_q #(
        .DATA_WIDTH (32),
        .DEPTH_LOG2 (7),
        .INIT_MULT  (3),
        .CNT_WIDTH  (16)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_flush       (i_flush),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_address     (i_address),
        .o_resp_valid  (o_resp_valid),
        .i_resp_ready  (i_resp_ready),
        .o_resp_data   (o_resp_data),
        .o_resp_err    (o_resp_err),
        .o_fetch_count (o_fetch_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: {err, data} of every accepted request, oldest first.
    logic [32:0] exp_q[$];
    logic [15:0] exp_cnt = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          resp_seen = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: memory word i = 3*i, 128 words, byte-addressed.
    function automatic logic [32:0] model(input logic [31:0] addr);
        logic [31:0] idx;
        if (addr % 4 != 0 || addr >= 32'd512) return {1'b1, 32'd0};
        idx = addr / 4;
        return {1'b0, idx * 32'd3};
    endfunction

    // One clock cycle of stimulus; expected response enters the scoreboard
    // after the edge that accepts it.
    task automatic step(input logic v, input logic [31:0] a, input logic rr,
                        input logic fl, input logic rs);
        bit acc;
        i_req_valid  = v;
        i_address    = a;
        i_resp_ready = rr;
        i_flush      = fl;
        i_reset      = rs;
        @(negedge clk);
        acc = v && o_req_ready && !rs;
        @(posedge clk);
        #1;
        if (rs) begin
            exp_q.delete();
            exp_cnt = '0;
        end else if (fl) begin
            exp_q.delete();
        end else if (acc) begin
            exp_q.push_back(model(a));
            exp_cnt = exp_cnt + 16'd1;
        end
        $display("cyc t=%0t v=%0b a=0x%08h rr=%0b fl=%0b rs=%0b acc=%0b q=%0d cnt=%0d",
                 $time, v, a, rr, fl, rs, acc, exp_q.size(), exp_cnt);
    endtask

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("resp_valid", 64'(o_resp_valid), 64'(exp_q.size() != 0));
            chk("req_ready", 64'(o_req_ready), 64'(!i_flush && exp_q.size() < 2));
            chk("fetch_count", 64'(o_fetch_count), 64'(exp_cnt));
            if (o_resp_valid && exp_q.size() != 0) begin
                chk("resp_data", 64'(o_resp_data), 64'(exp_q[0][31:0]));
                chk("resp_err", 64'(o_resp_err), 64'(exp_q[0][32]));
                if (i_resp_ready && !i_flush && !i_reset) begin
                    void'(exp_q.pop_front());
                    resp_seen++;
                end
            end
        end
    end

    initial begin
        int base_seen;
        logic [15:0] base_cnt;
        logic [31:0] a;
        int r;

        // Reset
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        mon_en = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("rst_valid", 64'(o_resp_valid), 64'd0);
        chk("rst_data", 64'(o_resp_data), 64'd0);
        chk("rst_err", 64'(o_resp_err), 64'd0);
        chk("rst_count", 64'(o_fetch_count), 64'd0);
        chk("rst_ready", 64'(o_req_ready), 64'd1);

        // Single fetch
        step(1, 32'h14, 0, 0, 0);
        chk("single_valid", 64'(o_resp_valid), 64'd1);
        chk("single_data", 64'(o_resp_data), 64'd15);
        chk("single_err", 64'(o_resp_err), 64'd0);
        chk("single_count", 64'(o_fetch_count), 64'd1);
        step(0, 0, 1, 0, 0);

        // Streaming full memory
        base_seen = resp_seen;
        base_cnt  = o_fetch_count;
        for (int i = 0; i < 128; i++) step(1, 32'(i * 4), 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("stream_resps", 64'(resp_seen - base_seen), 64'd128);
        chk("stream_count", 64'(o_fetch_count - base_cnt), 64'd128);

        // Backpressure
        step(1, 32'h8, 0, 0, 0);
        step(1, 32'hC, 0, 0, 0);
        chk("bp_ready_full", 64'(o_req_ready), 64'd0);
        chk("bp_hold_data", 64'(o_resp_data), 64'd6);
        step(0, 0, 0, 0, 0);
        chk("bp_hold_data2", 64'(o_resp_data), 64'd6);
        step(0, 0, 1, 0, 0);
        chk("bp_second", 64'(o_resp_data), 64'd9);
        chk("bp_ready_back", 64'(o_req_ready), 64'd1);
        step(0, 0, 1, 0, 0);

        // Errors
        base_cnt = o_fetch_count;
        step(1, 32'h200, 0, 0, 0);
        chk("err_range_flag", 64'(o_resp_err), 64'd1);
        chk("err_range_data", 64'(o_resp_data), 64'd0);
        step(1, 32'h6, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("err_align_flag", 64'(o_resp_err), 64'd1);
        chk("err_align_data", 64'(o_resp_data), 64'd0);
        chk("err_count", 64'(o_fetch_count - base_cnt), 64'd2);
        step(0, 0, 1, 0, 0);

        // Flush
        step(0, 0, 0, 0, 1);
        step(1, 32'h10, 0, 0, 0);
        step(1, 32'h14, 0, 0, 0);
        step(1, 32'h18, 1, 1, 0);
        chk("flush_valid", 64'(o_resp_valid), 64'd0);
        chk("flush_count", 64'(o_fetch_count), 64'd2);

        // Reset mid-operation with a request pending
        step(1, 32'h20, 0, 0, 0);
        step(1, 32'h24, 0, 0, 0);
        step(1, 32'h28, 1, 0, 1);
        chk("rst2_valid", 64'(o_resp_valid), 64'd0);
        chk("rst2_count", 64'(o_fetch_count), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      a = $urandom;
            else if (r == 1) a = (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
            else             a = 32'($urandom_range(0, 127)) << 2;
            step(logic'($urandom_range(0, 3) != 0), a,
                 logic'($urandom_range(0, 2) != 0),
                 logic'($urandom_range(0, 49) == 0),
                 logic'($urandom_range(0, 299) == 0));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        chk("drain_empty", 64'(o_resp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_fetch_q.md
Name: instr_mem_fetch_q

Overview:
Parametrised read-only instruction memory with a request/response handshake and a 2-entry in-order response queue. The fetch stage presents word-aligned byte addresses. The block returns one instruction word per accepted request, one cycle later. It replaces the purely combinational instruction ROM and adds range/alignment error reporting, backpressure, flush and an accepted-fetch counter.

Parameters:
DATA_WIDTH, 32, width of one instruction word in bits
DEPTH_LOG2, 7, log2 of memory depth in words (default 128 words)
INIT_MULT, 3, initialisation multiplier: word i = i*INIT_MULT, truncated to DATA_WIDTH
CNT_WIDTH, 16, width of the accepted-fetch counter

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Flush  input  1  synchronous discard of all queued responses
ReqValid  input  1  fetch request present
ReqReady  output  1  block can accept a request this cycle
Address  input  32  byte address of requested instruction
RespValid  output  1  head-of-queue response valid
RespReady  input  1  consumer accepts head response this cycle
RespData  output  DATA_WIDTH  instruction word
RespErr  output  1  request was out of range or misaligned
FetchCount  output  CNT_WIDTH  number of accepted requests since reset

Behaviour:
- Storage: 2**DEPTH_LOG2 words, loaded at time 0 with word[i] = (i*INIT_MULT) mod 2**DATA_WIDTH. Read-only. Reset and Flush do not alter contents.
- Index = Address[DEPTH_LOG2+1:2]. Address[1:0] selects a byte and is not used for indexing.
- Error: RespErr=1 and RespData=0 if Address[1:0]!=0 (misaligned) or Address[31:DEPTH_LOG2+2]!=0 (out of range). Otherwise RespErr=0 and RespData=word[index].
- Accept: a request is taken on a rising edge where ReqValid && ReqReady. Address is sampled at that edge only.
- ReqReady = !Flush && (Count < 2). Count is the internal queue occupancy, 0..2. ReqReady has no combinational path from ReqValid, Address or RespReady.
- Pop: the head entry is removed on a rising edge where RespValid && RespReady.
- Latency: a request accepted at edge N with an empty queue is visible at RespValid/RespData/RespErr right after edge N. The consumer can take it at edge N+1.
- Queue order is strictly FIFO. Simultaneous accept and pop at Count=1 leaves Count=1, with the new entry at the head.
- Throughput: with RespReady held high, one response per cycle is sustained indefinitely.
- Full (Count=2): ReqReady=0. A pop alone takes Count to 1, and ReqReady rises the following cycle.
- Empty (Count=0): RespValid=0. RespData and RespErr hold their last values; they are don't-care for checking.
- Stability: while RespValid=1 and RespReady=0, RespData and RespErr hold constant.
- RespValid = (Count != 0).
- Flush (Reset=0): on the edge, Count becomes 0. No accept occurs that cycle because ReqReady is forced 0. Any pop that cycle is irrelevant. FetchCount is unchanged. RespValid=0 the following cycle.
- FetchCount increments by 1 per accepted request, including error requests. It wraps from 2**CNT_WIDTH-1 to 0.
- Reset, which has priority over Flush and all handshakes, sets on the edge:
  - Count=0, so RespValid=0
  - RespData=0, RespErr=0
  - FetchCount=0
  - ReqReady=1 from the next cycle, provided Flush=0
- Reset mid-operation discards all queued entries with no response.
- Parameter check: DEPTH_LOG2 must be between 1 and 30, and DATA_WIDTH at least 1.

Test Plan:
- Reset: assert Reset 2 cycles, then release -> RespValid=0, RespData=0, RespErr=0, FetchCount=0, ReqReady=1.
- Single fetch: Address=0x0000_0014, ReqValid for one cycle -> after that edge RespValid=1, RespData=15 (index 5 * 3), RespErr=0, FetchCount=1.
- Streaming with RespReady=1:
  - Stimulus: Address 0x0,0x4,...,0x1FC on consecutive cycles.
  - Required: 128 responses on 128 consecutive cycles, data 0,3,...,381, in order.
  - Required: ReqReady never drops, FetchCount=128.
- Backpressure with RespReady=0:
  - Stimulus: issue 0x8 then 0xC.
  - Required: ReqReady=0 at Count=2, and RespData holds 6.
  - Then raise RespReady: required data 6 then 9, and ReqReady returns after the first pop.
- Errors:
  - Address=0x0000_0200 -> RespErr=1, RespData=0.
  - Address=0x0000_0006 -> RespErr=1, RespData=0.
  - Both increment FetchCount.
- Flush and reset:
  - Fill the queue with 0x10 and 0x14, then pulse Flush -> next cycle RespValid=0, Count=0, FetchCount=2.
  - Refill, then pulse Reset with ReqValid=1 -> no accept, FetchCount=0, RespValid=0.
